// File: rtl/laser_pool.sv
// Pool of NB_SHOTS player projectiles: launch on fire edge, climb on enable,
// retire on hit or screen exit; merged shot colour for the pixel path.
module laser_pool #(
   parameter int         NB_SHOTS     = 4,
   parameter int         SPACESHIP_Y  = 440,
   parameter int         SCREEN_TOP   = 0,
   parameter int         LASER_WIDTH  = 2,
   parameter int         LASER_HEIGHT = 10,
   parameter int         STEP         = 4,
   parameter int         COOLDOWN     = 2,
   parameter int         H_VISIBLE    = 640,
   parameter logic [2:0] COLOR        = 3'b100
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          enable,
   input  logic                          fire,
   input  logic [9:0]                    gunPosition,
   input  logic [NB_SHOTS-1:0]           hit,
   input  logic [9:0]                    hPos,
   input  logic [9:0]                    vPos,
   output logic [10*NB_SHOTS-1:0]        xLaser,
   output logic [10*NB_SHOTS-1:0]        yLaser,
   output logic [NB_SHOTS-1:0]           active,
   output logic [$clog2(NB_SHOTS+1)-1:0] nbActive,
   output logic                          dropped,
   output logic [2:0]                    colorLaser
);

   localparam int CNT_W = $clog2(NB_SHOTS+1);
   localparam int CD_W  = (COOLDOWN < 2) ? 1 : $clog2(COOLDOWN+1);
   localparam logic [9:0] X_MAX   = 10'(H_VISIBLE - LASER_WIDTH);
   localparam logic [9:0] Y_START = 10'(SPACESHIP_Y - LASER_HEIGHT);
   localparam logic [9:0] Y_EXIT  = 10'(SCREEN_TOP + STEP);
   localparam logic [9:0] STEP_V  = 10'(STEP);
   localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN);

   typedef enum logic {IDLE = 1'b0, FLYING = 1'b1} slot_e;

   slot_e          state_q [NB_SHOTS];
   slot_e          state_d [NB_SHOTS];
   logic [9:0]     x_q [NB_SHOTS];
   logic [9:0]     x_d [NB_SHOTS];
   logic [9:0]     y_q [NB_SHOTS];
   logic [9:0]     y_d [NB_SHOTS];
   logic           fire_d;
   logic [CD_W-1:0] cool_q;
   logic [CD_W-1:0] cool_d;
   logic           drop_d;
   logic           fire_edge;
   logic           launch;
   logic [NB_SHOTS-1:0] pick;
   logic [9:0]     x_launch;

   // pick is the lowest IDLE slot as seen at the start of the cycle
   always_comb begin : launch_sel
      fire_edge = fire & ~fire_d;
      pick      = '0;
      for (int i = 0; i < NB_SHOTS; i++) begin
         if (state_q[i] == IDLE && pick == '0) pick[i] = 1'b1;
      end
      launch   = fire_edge && (cool_q == '0) && (pick != '0);
      drop_d   = fire_edge && !launch;
      x_launch = (gunPosition > X_MAX) ? X_MAX : gunPosition;
      cool_d   = cool_q;
      if (launch) cool_d = CD_LOAD;
      else if (enable && cool_q != '0) cool_d = cool_q - 1'b1;
   end

   always_comb begin : slot_next
      for (int i = 0; i < NB_SHOTS; i++) begin
         state_d[i] = state_q[i];
         x_d[i]     = x_q[i];
         y_d[i]     = y_q[i];
         unique case (state_q[i])
            IDLE: begin
               if (launch && pick[i]) begin
                  state_d[i] = FLYING;
                  x_d[i]     = x_launch;
                  y_d[i]     = Y_START;
               end
            end
            FLYING: begin
               if (hit[i] || (enable && y_q[i] < Y_EXIT)) begin
                  state_d[i] = IDLE;
                  x_d[i]     = '0;
                  y_d[i]     = '0;
               end else if (enable) begin
                  y_d[i] = y_q[i] - STEP_V;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NB_SHOTS; i++) begin
            state_q[i] <= IDLE;
            x_q[i]     <= '0;
            y_q[i]     <= '0;
         end
         fire_d  <= 1'b0;
         cool_q  <= '0;
         dropped <= 1'b0;
      end else begin
         for (int i = 0; i < NB_SHOTS; i++) begin
            state_q[i] <= state_d[i];
            x_q[i]     <= x_d[i];
            y_q[i]     <= y_d[i];
         end
         fire_d  <= fire;
         cool_q  <= cool_d;
         dropped <= drop_d;
      end
   end

   // 11-bit bounds so a shot at the right/bottom edge cannot wrap
   always_comb begin : outs
      xLaser     = '0;
      yLaser     = '0;
      active     = '0;
      nbActive   = '0;
      colorLaser = '0;
      for (int i = 0; i < NB_SHOTS; i++) begin
         active[i]         = (state_q[i] == FLYING);
         xLaser[10*i +: 10] = x_q[i];
         yLaser[10*i +: 10] = y_q[i];
         nbActive          = nbActive + CNT_W'(active[i]);
         if (active[i]
             && hPos >= x_q[i]
             && {1'b0, hPos} < {1'b0, x_q[i]} + 11'(LASER_WIDTH)
             && vPos >= y_q[i]
             && {1'b0, vPos} < {1'b0, y_q[i]} + 11'(LASER_HEIGHT))
            colorLaser = COLOR;
      end
   end

endmodule

// File: tb/tb_laser_pool.sv
// Directed bench for laser_pool with a cycle-level reference model
// compared on every falling edge, plus hand-computed checkpoints.
module tb_laser_pool;

   localparam int NB = 4;
   localparam int STEP = 4;
   localparam int CD = 2;
   localparam int Y0 = 430;
   localparam int XMAX = 638;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        enable = 1'b0;
   logic        fire = 1'b0;
   logic [9:0]  gunPosition = '0;
   logic [NB-1:0] hit = '0;
   logic [9:0]  hPos = '0;
   logic [9:0]  vPos = '0;
   logic [10*NB-1:0] xLaser;
   logic [10*NB-1:0] yLaser;
   logic [NB-1:0] active;
   logic [2:0]  nbActive;
   logic        dropped;
   logic [2:0]  colorLaser;

   int n_chk = 0;
   int n_fail = 0;
   bit cmp_on = 0;

   bit   m_act [NB];
   int   m_x [NB];
   int   m_y [NB];
   int   m_cool;
   bit   m_fire_d;
   bit   m_drop;

   laser_pool #(.NB_SHOTS(NB)) dut (
      .clk(clk),
      .reset(reset),
      .enable(enable),
      .fire(fire),
      .gunPosition(gunPosition),
      .hit(hit),
      .hPos(hPos),
      .vPos(vPos),
      .xLaser(xLaser),
      .yLaser(yLaser),
      .active(active),
      .nbActive(nbActive),
      .dropped(dropped),
      .colorLaser(colorLaser)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input longint act, input longint exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int xs(input int i);
      return int'(xLaser[10*i +: 10]);
   endfunction

   function automatic int ys(input int i);
      return int'(yLaser[10*i +: 10]);
   endfunction

   function automatic int exp_color();
      int c;
      c = 0;
      for (int i = 0; i < NB; i++)
         if (m_act[i] && hPos >= m_x[i] && hPos < m_x[i] + 2
             && vPos >= m_y[i] && vPos < m_y[i] + 10)
            c = 4;
      return c;
   endfunction

   always @(posedge clk or negedge reset) begin : model
      bit fe;
      bit go;
      int slot;
      if (!reset) begin
         for (int i = 0; i < NB; i++) begin
            m_act[i] = 0;
            m_x[i] = 0;
            m_y[i] = 0;
         end
         m_cool = 0;
         m_fire_d = 0;
         m_drop = 0;
      end else begin
         fe = fire && !m_fire_d;
         slot = -1;
         for (int i = NB - 1; i >= 0; i--)
            if (!m_act[i]) slot = i;
         go = fe && m_cool == 0 && slot >= 0;
         for (int i = 0; i < NB; i++) begin
            if (m_act[i]) begin
               if (hit[i] || (enable && m_y[i] < STEP)) begin
                  m_act[i] = 0;
                  m_x[i] = 0;
                  m_y[i] = 0;
               end else if (enable) begin
                  m_y[i] = m_y[i] - STEP;
               end
            end
         end
         if (go) begin
            m_act[slot] = 1;
            m_x[slot] = (gunPosition > XMAX) ? XMAX : int'(gunPosition);
            m_y[slot] = Y0;
         end
         m_drop = fe && !go;
         if (go) m_cool = CD;
         else if (enable && m_cool > 0) m_cool--;
         m_fire_d = fire;
      end
   end

   always @(negedge clk) begin : compare
      int nb;
      if (cmp_on) begin
         nb = 0;
         for (int i = 0; i < NB; i++) begin
            chk($sformatf("m_act%0d", i), active[i], m_act[i]);
            chk($sformatf("m_x%0d", i), xs(i), m_x[i]);
            chk($sformatf("m_y%0d", i), ys(i), m_y[i]);
            nb += int'(m_act[i]);
         end
         chk("m_nb", nbActive, nb);
         chk("m_drop", dropped, m_drop);
         chk("m_color", colorLaser, exp_color());
      end
   end

   task automatic cyc(input logic en, input logic f, input logic [NB-1:0] h);
      enable = en;
      fire = f;
      hit = h;
      @(posedge clk);
      #2;
      enable = 0;
      hit = '0;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #2 reset = 1;
      cmp_on = 1;
      chk("rst_active", active, 0);
      chk("rst_nb", nbActive, 0);
      chk("rst_drop", dropped, 0);

      gunPosition = 300;
      cyc(0, 1, 0);
      chk("l_active", active, 4'b0001);
      chk("l_x0", xs(0), 300);
      chk("l_y0", ys(0), 430);
      cyc(1, 1, 0);
      cyc(0, 0, 0);
      cyc(0, 1, 0);
      chk("cd_drop", dropped, 1);
      chk("cd_active", active, 4'b0001);
      cyc(0, 1, 0);
      chk("cd_pulse", dropped, 0);
      cyc(1, 1, 0);
      cyc(1, 1, 0);
      chk("mv_y0", ys(0), 418);
      hPos = 301;
      vPos = 420;
      #1 chk("px_on", colorLaser, 3'b100);
      hPos = 302;
      #1 chk("px_off", colorLaser, 0);
      hPos = 0;
      vPos = 0;
      cyc(0, 0, 0);
      cyc(0, 1, 0);
      chk("l2_active", active, 4'b0011);
      chk("l2_nb", nbActive, 2);

      cyc(1, 0, 0);
      cyc(1, 0, 0);
      cyc(0, 1, 0);
      cyc(1, 0, 0);
      cyc(1, 0, 0);
      cyc(0, 1, 0);
      chk("full_active", active, 4'b1111);
      cyc(1, 0, 0);
      cyc(1, 0, 0);
      cyc(0, 1, 0);
      chk("full_drop", dropped, 1);
      chk("full_nb", nbActive, 4);
      cyc(0, 0, 4'b0100);
      chk("hit_active", active, 4'b1011);
      chk("hit_y2", ys(2), 0);
      cyc(0, 1, 0);
      chk("refill_active", active, 4'b1111);
      chk("refill_y2", ys(2), 430);

      cyc(1, 0, 0);
      cyc(1, 0, 0);
      cyc(0, 1, 4'b0001);
      chk("hitfire_active", active, 4'b1110);
      chk("hitfire_drop", dropped, 1);
      cyc(1, 0, 4'b0010);
      chk("hiten_active", active, 4'b1100);
      chk("hiten_y1", ys(1), 0);
      cyc(0, 0, 4'b0001);
      chk("hitidle_active", active, 4'b1100);

      for (int k = 0; k < 200 && m_y[2] != 6; k++) cyc(1, 0, 0);
      chk("ex_y6", ys(2), 6);
      cyc(1, 0, 0);
      chk("ex_y2", ys(2), 2);
      chk("ex_live", active[2], 1);
      cyc(1, 0, 0);
      chk("ex_gone", active[2], 0);
      chk("ex_y0", ys(2), 0);

      gunPosition = 639;
      cyc(0, 0, 0);
      cyc(0, 1, 0);
      chk("clamp_active", active, 4'b0001);
      chk("clamp_x0", xs(0), 638);

      cyc(1, 0, 0);
      cyc(1, 0, 0);
      cyc(0, 0, 0);
      cyc(0, 1, 0);
      chk("pre_rst_active", active, 4'b0011);
      reset = 0;
      #1;
      chk("mid_rst_active", active, 0);
      chk("mid_rst_nb", nbActive, 0);
      chk("mid_rst_x", (xLaser == '0), 1);
      chk("mid_rst_y", (yLaser == '0), 1);
      repeat (2) @(posedge clk);
      #2 reset = 1;
      fire = 0;
      @(posedge clk);
      #2;
      cmp_on = 0;
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
